// File: rtl/gw_serdes_pkg.sv
// ============================================================================
// gw_serdes_pkg: state encoding, limits and helpers shared by the serdes
// primitives (serializer and deserializer).
// Revision: 1.0
// ============================================================================
`default_nettype none

package gw_serdes_pkg;

  localparam int WIDTH_MAX = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/oser_bitcnt.sv
// ============================================================================
// oser_bitcnt: loadable down-counter that flags the last bit of a frame.
// Revision: 1.0
// ============================================================================
`default_nettype none

module oser_bitcnt #(
  parameter int CW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  output logic          last_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Holds at zero once reached; only a reload restarts it.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/oser_sync.sv
// ============================================================================
// oser_sync: parallel-to-serial transmitter with LOAD/READY handshake and FRAME
// marker. Optional parity bit when OSER_PARITY_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module oser_sync
  import gw_serdes_pkg::*;
#(
  parameter int   WIDTH     = 4,
  parameter logic LSB_FIRST = 1'b1,
  parameter logic INIT      = 1'b0
`ifdef OSER_PARITY_EN
  ,
  parameter logic PARITY_ODD = 1'b0
`endif
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD,
  output logic             READY,
  output logic             Q,
  output logic             FRAME,
  output logic             BUSY
);

`ifdef OSER_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int CW = clog2(FLEN + 1);

  if ((WIDTH < 2) || (WIDTH > WIDTH_MAX)) begin : g_width_bad
    $error("oser_sync: WIDTH out of range");
  end

  state_t            state_q, state_d;
  logic [FLEN-1:0]   sr_q, sr_d;
  logic              q_q, q_d;
  logic              frame_q, frame_d;
  logic              busy_q, busy_d;

  logic [WIDTH-1:0]  w_data;
  logic [FLEN-1:0]   w_frame;
  logic              w_last;
  logic              w_ready;
  logic              w_accept;

  // Reorder so that bit 0 of the frame word is always the first bit on the wire.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_data[i] = LSB_FIRST ? D[i] : D[WIDTH-1-i];
    end
  end

`ifdef OSER_PARITY_EN
  assign w_frame = {(^D) ^ PARITY_ODD, w_data};
`else
  assign w_frame = w_data;
`endif

  assign w_ready  = !RESET && ((state_q == ST_IDLE) || ((state_q == ST_SHIFT) && w_last));
  assign w_accept = LOAD && w_ready;

  oser_bitcnt #(
    .CW(CW)
  ) u_bitcnt (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .load_i     (w_accept),
    .load_val_i (CW'(FLEN - 1)),
    .en_i       (state_q == ST_SHIFT),
    .last_o     (w_last)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    q_d     = q_q;
    frame_d = 1'b0;
    busy_d  = busy_q;
    if (w_accept) begin
      state_d = ST_SHIFT;
      q_d     = w_frame[0];
      sr_d    = {1'b0, w_frame[FLEN-1:1]};
      frame_d = 1'b1;
      busy_d  = 1'b1;
    end else if (state_q == ST_SHIFT) begin
      if (w_last) begin
        state_d = ST_IDLE;
        q_d     = INIT;
        busy_d  = 1'b0;
      end else begin
        q_d     = sr_q[0];
        sr_d    = {1'b0, sr_q[FLEN-1:1]};
        busy_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      q_q     <= INIT;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      q_q     <= q_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
    end
  end

  assign READY = w_ready;
  assign Q     = q_q;
  assign FRAME = frame_q;
  assign BUSY  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_oser_sync.sv
// ============================================================================
// tb_oser_sync: two serializers (LSB-first and MSB-first) driven in parallel
// and compared every cycle against a bit-queue model of the transmitter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_oser_sync;

`ifdef OSER_PARITY_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif
  localparam logic PAR_ODD = 1'b0;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] D;
  logic       LOAD;
  logic       ready_l, q_l, frame_l, busy_l;
  logic       ready_m, q_m, frame_m, busy_m;

  int n_chk = 0;
  int n_bad = 0;

  bit pend_l[$];
  bit pend_m[$];
  bit cur_q_l, cur_q_m, cur_f, cur_b;

  always #5 CLK = ~CLK;

  oser_sync #(.WIDTH(4), .LSB_FIRST(1'b1), .INIT(1'b0)) dut_l (
    .CLK(CLK), .RESET(RESET), .D(D), .LOAD(LOAD),
    .READY(ready_l), .Q(q_l), .FRAME(frame_l), .BUSY(busy_l)
  );

  oser_sync #(.WIDTH(4), .LSB_FIRST(1'b0), .INIT(1'b0)) dut_m (
    .CLK(CLK), .RESET(RESET), .D(D), .LOAD(LOAD),
    .READY(ready_m), .Q(q_m), .FRAME(frame_m), .BUSY(busy_m)
  );

  task automatic check(input string tag, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, act, exp);
    end
  endtask

  // Model: what the line shows now, plus the bits still owed for this frame.
  task automatic model_edge(input bit r, input bit ld, input logic [3:0] d);
    bit rdy;
    rdy = !r && (pend_l.size() == 0);
    if (r) begin
      pend_l.delete();
      pend_m.delete();
      cur_q_l = 1'b0; cur_q_m = 1'b0; cur_f = 1'b0; cur_b = 1'b0;
    end else if (ld && rdy) begin
      for (int i = 0; i < 4; i++) pend_l.push_back(d[i]);
      for (int i = 3; i >= 0; i--) pend_m.push_back(d[i]);
      if (FLEN == 5) begin
        pend_l.push_back(((d[0] + d[1] + d[2] + d[3]) % 2 == 1) ^ PAR_ODD);
        pend_m.push_back(((d[0] + d[1] + d[2] + d[3]) % 2 == 1) ^ PAR_ODD);
      end
      cur_q_l = pend_l.pop_front();
      cur_q_m = pend_m.pop_front();
      cur_f = 1'b1; cur_b = 1'b1;
    end else if (pend_l.size() > 0) begin
      cur_q_l = pend_l.pop_front();
      cur_q_m = pend_m.pop_front();
      cur_f = 1'b0; cur_b = 1'b1;
    end else begin
      cur_q_l = 1'b0; cur_q_m = 1'b0; cur_f = 1'b0; cur_b = 1'b0;
    end
  endtask

  // Called just after a falling edge: apply inputs, check, then take the edge.
  task automatic step(input bit r, input bit ld, input logic [3:0] d);
    bit exp_rdy;
    RESET = r; LOAD = ld; D = d;
    #1;
    exp_rdy = !r && (pend_l.size() == 0);
    check("ready_lsb", ready_l, exp_rdy);
    check("ready_msb", ready_m, exp_rdy);
    check("q_lsb",     q_l,     cur_q_l);
    check("q_msb",     q_m,     cur_q_m);
    check("frame_lsb", frame_l, cur_f);
    check("frame_msb", frame_m, cur_f);
    check("busy_lsb",  busy_l,  cur_b);
    check("busy_msb",  busy_m,  cur_b);
    @(posedge CLK);
    model_edge(r, ld, d);
    @(negedge CLK);
  endtask

  initial begin
    RESET = 1'b1; LOAD = 1'b1; D = 4'hA;
    @(posedge CLK);
    model_edge(1'b1, 1'b1, 4'hA);
    @(negedge CLK);

    // Reset dominates a pending LOAD.
    repeat (3) step(1'b1, 1'b1, 4'hA);
    repeat (3) step(1'b0, 1'b0, 4'h0);

    // Single frame, then return to idle.
    step(1'b0, 1'b1, 4'b1011);
    repeat (FLEN + 2) step(1'b0, 1'b0, 4'h0);

    // Back-to-back frames with accept on the last-bit cycle.
    step(1'b0, 1'b1, 4'hC);
    repeat (FLEN - 1) step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h3);
    repeat (FLEN + 1) step(1'b0, 1'b0, 4'h0);

    // LOAD held and D toggling mid-frame must not disturb the frame.
    step(1'b0, 1'b1, 4'h9);
    for (int i = 0; i < FLEN - 1; i++) step(1'b0, 1'b1, (i % 2 == 0) ? 4'h6 : 4'hF);
    repeat (FLEN + 1) step(1'b0, 1'b0, 4'h0);

    // Reset on the second bit aborts; next word goes out cleanly.
    step(1'b0, 1'b1, 4'h6);
    step(1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h5);
    repeat (FLEN + 1) step(1'b0, 1'b0, 4'h0);

    // Parity word from the directed plan (also harmless without parity).
    step(1'b0, 1'b1, 4'b0111);
    repeat (FLEN + 1) step(1'b0, 1'b0, 4'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1), 4'($urandom));
    end
    repeat (FLEN + 1) step(1'b0, 1'b0, 4'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
